// File: rtl/tmp117_i2c_target.sv
// I2C target emulating the TMP117 register map (temperature, configuration, device ID).
// SCL/SDA are synchronized and edge-detected locally; SDA is driven open-drain via o_sda_oe.
module tmp117_i2c_target #(
  parameter logic [6:0]  SLAVE_ADD    = 7'b1001000,
  parameter logic [15:0] CONFIG_RESET = 16'h0220,
  parameter logic [15:0] DEVICE_ID    = 16'h0117
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_scl,
  input  logic        i_sda,
  output logic        o_sda_oe,
  input  logic [15:0] i_temp_data,
  input  logic        i_temp_valid,
  output logic [15:0] o_config,
  output logic        o_config_wr,
  output logic        o_busy
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] ADDR     = 4'd1;
  localparam logic [3:0] ADDR_ACK = 4'd2;
  localparam logic [3:0] PTR      = 4'd3;
  localparam logic [3:0] PTR_ACK  = 4'd4;
  localparam logic [3:0] WR_DATA  = 4'd5;
  localparam logic [3:0] WR_ACK   = 4'd6;
  localparam logic [3:0] RD_DATA  = 4'd7;
  localparam logic [3:0] RD_ACK   = 4'd8;
  localparam logic [3:0] IGNORE   = 4'd9;

  logic        scl_p0, scl_p1, scl_p2;
  logic        sda_p0, sda_p1, sda_p2;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [3:0]  state;
  logic [3:0]  bit_cnt;
  logic        rw;
  logic        byte_idx;
  logic [7:0]  shreg;
  logic [7:0]  staging;
  logic [7:0]  ptr;
  logic [15:0] temp_reg;
  logic [15:0] snap;
  logic [15:0] reg_sel;
  logic [7:0]  cur_byte;
  logic        tx_bit;

  // p0/p1: two-flop synchronizer, p2: edge-detect delay (idle bus is high)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_p0 <= 1'b1; scl_p1 <= 1'b1; scl_p2 <= 1'b1;
      sda_p0 <= 1'b1; sda_p1 <= 1'b1; sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= i_scl; scl_p1 <= scl_p0; scl_p2 <= scl_p1;
      sda_p0 <= i_sda; sda_p1 <= sda_p0; sda_p2 <= sda_p1;
    end
  end

  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

  always_comb begin
    reg_sel = 16'h0000;
    case (ptr)
      8'h00:   reg_sel = temp_reg;
      8'h01:   reg_sel = o_config;
      8'h0F:   reg_sel = DEVICE_ID;
      default: reg_sel = 16'h0000;
    endcase
  end

  assign cur_byte = byte_idx ? snap[7:0] : snap[15:8];
  assign tx_bit   = cur_byte[3'd7 - bit_cnt[2:0]];

  always_ff @(posedge i_clk) begin
    if (scl_rise && (state == ADDR || state == PTR || state == WR_DATA))
      shreg <= {shreg[6:0], sda_p1};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      rw          <= 1'b0;
      byte_idx    <= 1'b0;
      ptr         <= 8'h00;
      temp_reg    <= 16'h0000;
      o_sda_oe    <= 1'b0;
      o_config    <= CONFIG_RESET;
      o_config_wr <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_config_wr <= 1'b0;
      if (i_temp_valid) temp_reg <= i_temp_data;
      // Bus conditions pre-empt any bit processing in the same cycle
      if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= 4'd0;
        o_sda_oe <= 1'b0;
      end else if (stop_det) begin
        state    <= IDLE;
        o_sda_oe <= 1'b0;
        o_busy   <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WR_DATA: begin
            if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
            if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (state == ADDR) begin
                rw <= shreg[0];
                if (shreg[7:1] == SLAVE_ADD) begin
                  state    <= ADDR_ACK;
                  o_sda_oe <= 1'b1;
                  o_busy   <= 1'b1;
                end else begin
                  state  <= IGNORE;
                  o_busy <= 1'b0;
                end
              end else if (state == PTR) begin
                ptr      <= shreg;
                state    <= PTR_ACK;
                o_sda_oe <= 1'b1;
              end else begin
                if (!byte_idx) staging <= shreg;
                state    <= WR_ACK;
                o_sda_oe <= 1'b1;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (rw) begin
                state    <= RD_DATA;
                snap     <= reg_sel;
                o_sda_oe <= ~reg_sel[15];
                byte_idx <= 1'b0;
              end else begin
                state    <= PTR;
                o_sda_oe <= 1'b0;
              end
            end
          end
          PTR_ACK: begin
            if (scl_fall) begin
              state    <= WR_DATA;
              o_sda_oe <= 1'b0;
              byte_idx <= 1'b0;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              state    <= WR_DATA;
              o_sda_oe <= 1'b0;
              byte_idx <= ~byte_idx;
              // shreg still holds the LSB just acknowledged
              if (byte_idx && ptr == 8'h01) begin
                o_config    <= {staging, shreg};
                o_config_wr <= 1'b1;
              end
            end
          end
          RD_DATA: begin
            if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                state    <= RD_ACK;
                bit_cnt  <= 4'd0;
                o_sda_oe <= 1'b0;
              end else begin
                o_sda_oe <= ~tx_bit;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise && sda_p1) begin
              state <= IGNORE;
            end else if (scl_fall) begin
              state <= RD_DATA;
              if (!byte_idx) begin
                byte_idx <= 1'b1;
                o_sda_oe <= ~snap[7];
              end else begin
                byte_idx <= 1'b0;
                snap     <= reg_sel;
                o_sda_oe <= ~reg_sel[15];
              end
            end
          end
          IDLE, IGNORE: o_sda_oe <= 1'b0;
          default: begin
            state    <= IDLE;
            o_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tmp117_i2c_target.sv
// Directed bench for tmp117_i2c_target: a bit-banged I2C controller drives an open-drain SDA model.
module tb_tmp117_i2c_target;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        sda_c = 1'b1;
  logic [15:0] temp_data = 16'h0000;
  logic        temp_valid = 1'b0;
  logic        sda_oe;
  logic [15:0] cfg;
  logic        cfg_wr;
  logic        busy;
  wire         sda_line = sda_c & ~sda_oe;

  int n_cmp = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;

  always #5 clk = ~clk;

  tmp117_i2c_target #(
    .SLAVE_ADD(7'b1001000), .CONFIG_RESET(16'h0220), .DEVICE_ID(16'h0117)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_scl(scl), .i_sda(sda_line),
    .o_sda_oe(sda_oe), .i_temp_data(temp_data), .i_temp_valid(temp_valid),
    .o_config(cfg), .o_config_wr(cfg_wr), .o_busy(busy)
  );

  always @(negedge clk) begin
    if (cfg_wr) wr_cnt++;
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic q();
    repeat (10) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_c = 1'b1; q(); scl = 1'b1; q(); sda_c = 1'b0; q(); scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    sda_c = 1'b0; q(); scl = 1'b1; q(); sda_c = 1'b1; q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_c = b[i]; q(); scl = 1'b1; q(); q(); scl = 1'b0; q();
    end
    sda_c = 1'b1; q(); scl = 1'b1; q(); ack = sda_line; q(); scl = 1'b0; q();
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    sda_c = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      q(); scl = 1'b1; q(); b[i] = sda_line; q(); scl = 1'b0;
    end
    q(); sda_c = nack; q(); scl = 1'b1; q(); q(); scl = 1'b0; q(); sda_c = 1'b1;
  endtask

  task automatic temp_load(input logic [15:0] v);
    @(negedge clk); temp_data = v; temp_valid = 1'b1;
    @(negedge clk); temp_valid = 1'b0;
  endtask

  // Write a pointer, then repeated START with a read address; nak=1 if any byte was not ACKed
  task automatic set_ptr_read(input logic [7:0] p, output logic nak);
    logic a0, a1, a2;
    i2c_start();
    write_byte(8'h90, a0);
    write_byte(p, a1);
    i2c_start();
    write_byte(8'h91, a2);
    nak = a0 | a1 | a2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_oe got %b want 0", sda_oe); end
    n_cmp++; if (cfg !== 16'h0220) begin n_fail++; $display("FAIL rst_config got %h want 0220", cfg); end
    n_cmp++; if (cfg_wr !== 1'b0) begin n_fail++; $display("FAIL rst_config_wr got %b want 0", cfg_wr); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    rst = 1'b0;
    q();
  endtask

  task automatic test_config_write();
    logic [7:0] seq [6];
    logic ack;
    int w0;
    seq = '{8'h90, 8'h01, 8'h02, 8'h20, 8'h8C, 8'h00};
    w0 = wr_cnt;
    i2c_start();
    for (int i = 0; i < 6; i++) begin
      write_byte(seq[i], ack);
      n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL cfgwr_ack%0d got %b want 0", i, ack); end
    end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cfgwr_busy got %b want 1", busy); end
    i2c_stop(); q();
    n_cmp++; if (cfg !== 16'h8C00) begin n_fail++; $display("FAIL cfgwr_config got %h want 8c00", cfg); end
    n_cmp++; if (wr_cnt - w0 !== 2) begin n_fail++; $display("FAIL cfgwr_pulses got %0d want 2", wr_cnt - w0); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cfgwr_busy_stop got %b want 0", busy); end
  endtask

  task automatic test_temp_read();
    logic nak;
    logic [7:0] b0, b1;
    temp_load(16'h0C80);
    set_ptr_read(8'h00, nak);
    n_cmp++; if (nak !== 1'b0) begin n_fail++; $display("FAIL tread_acks got %b want 0", nak); end
    read_byte(1'b0, b0);
    read_byte(1'b1, b1);
    n_cmp++; if (b0 !== 8'h0C) begin n_fail++; $display("FAIL tread_msb got %h want 0c", b0); end
    n_cmp++; if (b1 !== 8'h80) begin n_fail++; $display("FAIL tread_lsb got %h want 80", b1); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tread_busy got %b want 1", busy); end
    i2c_stop(); q();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tread_busy_stop got %b want 0", busy); end
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    int oe0, busy0;
    oe0 = oe_cnt; busy0 = busy_cnt;
    i2c_start();
    write_byte(8'h92, a0);
    write_byte(8'h01, a1);
    i2c_stop(); q();
    n_cmp++; if (a0 !== 1'b1) begin n_fail++; $display("FAIL mism_addr_ack got %b want 1", a0); end
    n_cmp++; if (a1 !== 1'b1) begin n_fail++; $display("FAIL mism_data_ack got %b want 1", a1); end
    n_cmp++; if (oe_cnt - oe0 !== 0) begin n_fail++; $display("FAIL mism_oe cycles got %0d want 0", oe_cnt - oe0); end
    n_cmp++; if (busy_cnt - busy0 !== 0) begin n_fail++; $display("FAIL mism_busy cycles got %0d want 0", busy_cnt - busy0); end
    n_cmp++; if (cfg !== 16'h8C00) begin n_fail++; $display("FAIL mism_config got %h want 8c00", cfg); end
  endtask

  task automatic test_ptr_reads();
    logic nak;
    logic [7:0] b0, b1, b2, b3;
    set_ptr_read(8'h0F, nak);
    read_byte(1'b0, b0); read_byte(1'b1, b1); i2c_stop(); q();
    n_cmp++; if (nak !== 1'b0) begin n_fail++; $display("FAIL id_acks got %b want 0", nak); end
    n_cmp++; if ({b0, b1} !== 16'h0117) begin n_fail++; $display("FAIL id_read got %h want 0117", {b0, b1}); end
    set_ptr_read(8'h05, nak);
    read_byte(1'b0, b0); read_byte(1'b1, b1); i2c_stop(); q();
    n_cmp++; if ({b0, b1} !== 16'h0000) begin n_fail++; $display("FAIL unmapped_read got %h want 0000", {b0, b1}); end
    temp_load(16'h1234);
    set_ptr_read(8'h00, nak);
    read_byte(1'b0, b0); read_byte(1'b0, b1); read_byte(1'b0, b2); read_byte(1'b1, b3);
    i2c_stop(); q();
    n_cmp++; if ({b0, b1, b2, b3} !== 32'h12341234) begin
      n_fail++; $display("FAIL repeat_read got %h want 12341234", {b0, b1, b2, b3});
    end
  endtask

  task automatic test_coherency();
    logic nak, a;
    logic [7:0] b0, b1;
    temp_load(16'h0C80);
    set_ptr_read(8'h00, nak);
    read_byte(1'b0, b0);
    temp_load(16'hFFFF);
    read_byte(1'b1, b1);
    i2c_stop(); q();
    n_cmp++; if ({b0, b1} !== 16'h0C80) begin n_fail++; $display("FAIL coh_inflight got %h want 0c80", {b0, b1}); end
    i2c_start();
    write_byte(8'h91, a);
    read_byte(1'b0, b0); read_byte(1'b1, b1);
    i2c_stop(); q();
    n_cmp++; if (a !== 1'b0) begin n_fail++; $display("FAIL coh_addr_ack got %b want 0", a); end
    n_cmp++; if ({b0, b1} !== 16'hFFFF) begin n_fail++; $display("FAIL coh_next got %h want ffff", {b0, b1}); end
  endtask

  task automatic test_reset_mid();
    logic nak, a0, a1;
    logic [7:0] b0, b1;
    set_ptr_read(8'h0F, nak);
    // First data bit of 0x01 is 0, so the target is pulling SDA low here
    n_cmp++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_oe got %b want 1", sda_oe); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rmid_oe got %b want 0", sda_oe); end
    n_cmp++; if (cfg !== 16'h0220) begin n_fail++; $display("FAIL rmid_config got %h want 0220", cfg); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy); end
    rst = 1'b0;
    sda_c = 1'b1; q(); scl = 1'b1; q();
    i2c_start();
    write_byte(8'h90, a0);
    write_byte(8'h01, a1);
    n_cmp++; if ({a0, a1} !== 2'b00) begin n_fail++; $display("FAIL rmid_ack got %b want 00", {a0, a1}); end
    i2c_start();
    write_byte(8'h91, a0);
    read_byte(1'b0, b0); read_byte(1'b1, b1);
    i2c_stop(); q();
    n_cmp++; if ({b0, b1} !== 16'h0220) begin n_fail++; $display("FAIL rmid_cfg_read got %h want 0220", {b0, b1}); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_stop got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_config_write();
    test_temp_read();
    test_mismatch();
    test_ptr_reads();
    test_coherency();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
